// File: rtl/serial_fs_comparator.sv
// Bit-serial unsigned magnitude comparator: one full-subtractor cell plus a registered borrow,
// processing operands LSB-first and reporting gt/eq/lt and the full difference on completion.
module serial_fs_comparator #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [WIDTH-1:0] diff
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] dreg;
   logic             borrow;
   logic             nonzero;
   logic [CW-1:0]    cnt;

   logic             load_c;
   logic             shift_c;
   logic             last_c;
   logic             bit_a_c;
   logic             bit_b_c;
   logic             d_c;
   logic             bout_c;
   logic             nz_c;
   logic [WIDTH-1:0] diff_shift_c;

   // Single full-subtractor cell on the current LSBs and the registered borrow
   always_comb begin
      bit_a_c      = sa[0];
      bit_b_c      = sb[0];
      d_c          = bit_a_c ^ bit_b_c ^ borrow;
      bout_c       = (~bit_a_c & bit_b_c) | (~bit_a_c & borrow) | (bit_b_c & borrow);
      nz_c         = nonzero | d_c;
      diff_shift_c = {d_c, dreg[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and per-cycle datapath controls
   always_comb begin
      state_next = state;
      load_c     = 1'b0;
      shift_c    = 1'b0;
      last_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load_c     = 1'b1;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift_c = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               last_c     = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Status flags registered from the next state so they track the state register exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_next == S_SHIFT);
         done <= (state_next == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa      <= '0;
         sb      <= '0;
         dreg    <= '0;
         borrow  <= 1'b0;
         nonzero <= 1'b0;
         cnt     <= '0;
      end else if (load_c) begin
         sa      <= A;
         sb      <= B;
         dreg    <= '0;
         borrow  <= 1'b0;
         nonzero <= 1'b0;
         cnt     <= '0;
      end else if (shift_c) begin
         sa      <= sa >> 1;
         sb      <= sb >> 1;
         dreg    <= diff_shift_c;
         borrow  <= bout_c;
         nonzero <= nz_c;
         cnt     <= cnt + CW'(1);
      end
   end

   // Results only update on the final bit, so they hold through the next operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff <= '0;
         gt   <= 1'b0;
         eq   <= 1'b0;
         lt   <= 1'b0;
      end else if (last_c) begin
         diff <= diff_shift_c;
         lt   <= bout_c;
         eq   <= ~nz_c;
         gt   <= ~bout_c & nz_c;
      end
   end

endmodule
